seq_alu_accum: RTL

- Parametrised, registered successor to the 4-bit combinational lab ALU.
- W-bit operands; 2W-bit registered result that doubles as an accumulator; start/busy/done handshake.
- Adds subtract, accumulate and a multi-cycle shift-add multiply.
- Sits between board I/O (switches/keys) and LEDR/hex display logic, or can be driven by a controller FSM.

---
 rtl/alu_pkg.sv | 17 +
 rtl/seq_multiplier.sv | 48 ++++
 rtl/seq_alu_accum.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU/accumulator: opcode values and
// the two-state controller encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SEXT = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_CAT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_ACC  = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/seq_multiplier.sv
// W-bit unsigned shift-add multiplier datapath: load captures the operands,
// each step retires one multiplier bit; product is the post-step value.
module seq_multiplier #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           last
);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] prod;
  logic [CW-1:0]  cnt;

  // The product after this step; the caller latches it on the final step so
  // the result lands in the same edge that empties the counter.
  assign product = prod + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= CW'(W);
    end else if (step) begin
      prod   <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu_accum.sv
// Registered W-bit ALU with a 2W-bit result/accumulator register and a
// start/busy/done handshake; MUL runs W cycles on the shift-add datapath.
module seq_alu_accum
  import alu_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic           Clock,
  input  logic           Reset_b,
  input  logic           start,
  input  logic [2:0]     Function,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic           use_acc,
  output logic [2*W-1:0] ALUout,
  output logic           busy,
  output logic           done
);

  localparam int RW = 2 * W;

  logic [0:0]    state;
  logic          accept;
  logic          is_mul;
  logic [W-1:0]  ae;
  logic [W:0]    sum_ext;
  logic [RW-1:0] alu_result;
  logic [RW-1:0] mul_product;
  logic          mul_last;

  assign accept  = (state == ST_IDLE) && start;
  assign is_mul  = (Function == OP_MUL);
  assign ae      = use_acc ? ALUout[W-1:0] : A;
  assign sum_ext = {1'b0, ae} + {1'b0, B};
  assign busy    = (state == ST_BUSY);

  // NOTE: alu_result is assigned a default before the case so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    alu_result = ALUout;
    case (Function)
      OP_ADD:  alu_result = RW'(sum_ext);
      OP_SUB:  alu_result = {{W{1'b0}}, ae} - {{W{1'b0}}, B};
      OP_SEXT: alu_result = {{W{B[W-1]}}, B};
      OP_OR:   alu_result = {{(RW-1){1'b0}}, |{ae, B}};
      OP_AND:  alu_result = {{(RW-1){1'b0}}, &{ae, B}};
      OP_CAT:  alu_result = {ae, B};
      OP_ACC:  alu_result = ALUout + RW'(sum_ext);
      default: alu_result = ALUout;
    endcase
  end

  seq_multiplier #(.W(W), .CW(CW)) u_mul (
    .clk     (Clock),
    .rst_n   (Reset_b),
    .load    (accept && is_mul),
    .step    (busy),
    .a       (ae),
    .b       (B),
    .product (mul_product),
    .last    (mul_last)
  );

  // Reset clears the result too, so an aborted multiply leaves nothing behind.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state  <= ST_IDLE;
      ALUout <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_BUSY;
            end else begin
              ALUout <= alu_result;
              done   <= 1'b1;
            end
          end
        end
        default: begin
          if (mul_last) begin
            ALUout <= mul_product;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
